// File: rtl/uart_cmd_bridge_pkg.sv
// Shared types and constants for the UART command bridge: FSM states, status codes
// returned on the TX stream, and CMD byte field positions.
package uart_cmd_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StReq,
    StWaitRsp,
    StTxData,
    StTxStatus
  } state_e;

  localparam logic [7:0] STS_OK       = 8'h00;
  localparam logic [7:0] STS_BUS_ERR  = 8'h01;
  localparam logic [7:0] STS_INTG_ERR = 8'h02;
  localparam logic [7:0] STS_BAD_LEN  = 8'h03;
  localparam logic [7:0] STS_TIMEOUT  = 8'h04;

  localparam int unsigned CmdWrBit  = 7;
  localparam int unsigned CmdLenMsb = 3;

endpackage

// File: rtl/uart_cmd_bridge.sv
// Parses framed commands from the UART RX byte stream into word read/write bursts on the
// host request interface and returns read data plus a status byte on the TX stream.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int unsigned AddrBytes     = 4,
  parameter int unsigned MaxBurst      = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_pop_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic        valid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  input  logic        intg_err_i,
  output logic        busy_o
);

  localparam int unsigned     TmoW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [4:0]      MaxLen   = 5'(MaxBurst);
  localparam logic [1:0]      AddrLast = 2'(AddrBytes - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TimeoutCycles - 1);
  localparam bit              TmoEn    = (TimeoutCycles != 0);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [31:0]       base_q, base_d;
  logic [7:0]        status_q, status_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic [31:0] shreg_ins;
  logic [4:0]  cmd_len;
  logic [4:0]  idx_inc;
  logic        rx_wait;
  logic        tmo_hit;

  // One byte lane of the shared shift register is replaced by the incoming RX byte;
  // the same register holds the address, the write word and the read word in turn.
  always_comb begin
    shreg_ins = shreg_q;
    shreg_ins[{bcnt_q, 3'b000} +: 8] = rx_data_i;
  end

  assign cmd_len = {1'b0, rx_data_i[CmdLenMsb:0]} + 5'd1;
  assign idx_inc = idx_q + 5'd1;
  assign rx_wait = ((state_q == StAddr) || (state_q == StWdata)) && !rx_valid_i;
  assign tmo_hit = TmoEn && rx_wait && (tmo_q == TmoLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      base_q   <= '0;
      status_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      base_q   <= base_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    base_d   = base_q;
    status_d = status_q;
    tmo_d    = tmo_q;

    if (rx_pop_o) begin
      tmo_d = '0;
    end else if (TmoEn && rx_wait) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          we_d    = rx_data_i[CmdWrBit];
          len_d   = cmd_len;
          idx_d   = '0;
          bcnt_d  = '0;
          shreg_d = '0;
          if (cmd_len > MaxLen) begin
            status_d = STS_BAD_LEN;
            state_d  = StTxStatus;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (tmo_hit) begin
          status_d = STS_TIMEOUT;
          state_d  = StTxStatus;
        end else if (rx_valid_i) begin
          shreg_d = shreg_ins;
          if (bcnt_q == AddrLast) begin
            base_d  = {shreg_ins[31:2], 2'b00};
            bcnt_d  = '0;
            state_d = we_q ? StWdata : StReq;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      StWdata: begin
        if (tmo_hit) begin
          status_d = STS_TIMEOUT;
          state_d  = StTxStatus;
        end else if (rx_valid_i) begin
          shreg_d = shreg_ins;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (gnt_i) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (valid_i) begin
          if (intg_err_i) begin
            status_d = STS_INTG_ERR;
            state_d  = StTxStatus;
          end else if (err_i) begin
            status_d = STS_BUS_ERR;
            state_d  = StTxStatus;
          end else if (!we_q) begin
            shreg_d = rdata_i;
            bcnt_d  = '0;
            state_d = StTxData;
          end else begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
              status_d = STS_OK;
              state_d  = StTxStatus;
            end else begin
              state_d = StWdata;
            end
          end
        end
      end
      StTxData: begin
        if (tx_ready_i) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
              status_d = STS_OK;
              state_d  = StTxStatus;
            end else begin
              state_d = StReq;
            end
          end
        end
      end
      StTxStatus: begin
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_pop_o   = rx_valid_i &&
                 ((state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata));
    req_o      = (state_q == StReq);
    addr_o     = base_q + {25'd0, idx_q, 2'b00};
    we_o       = we_q;
    wdata_o    = shreg_q;
    be_o       = req_o ? 4'hF : 4'h0;
    busy_o     = (state_q != StIdle);
    tx_valid_o = (state_q == StTxData) || (state_q == StTxStatus);
    tx_data_o  = 8'h00;
    if (state_q == StTxData) begin
      tx_data_o = shreg_q[{bcnt_q, 3'b000} +: 8];
    end else if (state_q == StTxStatus) begin
      tx_data_o = status_q;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: a frame-level model predicts bus operations and TX bytes,
// a single compare process checks every handshake against those predictions.
module tb_uart_cmd_bridge;
  import uart_cmd_bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_pop_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        valid_i;
  logic [31:0] rdata_i;
  logic        err_i;
  logic        intg_err_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  uart_cmd_bridge #(
    .AddrBytes    (4),
    .MaxBurst     (4),
    .TimeoutCycles(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_valid_i(rx_valid_i),
    .rx_data_i (rx_data_i),
    .rx_pop_o  (rx_pop_o),
    .tx_valid_o(tx_valid_o),
    .tx_data_o (tx_data_o),
    .tx_ready_i(tx_ready_i),
    .req_o     (req_o),
    .gnt_i     (gnt_i),
    .addr_o    (addr_o),
    .we_o      (we_o),
    .wdata_o   (wdata_o),
    .be_o      (be_o),
    .valid_i   (valid_i),
    .rdata_i   (rdata_i),
    .err_i     (err_i),
    .intg_err_i(intg_err_i),
    .busy_o    (busy_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        intg;
  } rsp_t;

  logic [7:0] rx_mem [256];
  logic [7:0] exp_tx [256];
  op_t        exp_op [64];
  rsp_t       rsp_mem [64];
  int rx_wr = 0, rx_rd = 0, exp_tx_wr = 0, exp_tx_rd = 0;
  int exp_op_wr = 0, exp_op_rd = 0, rsp_wr = 0, rsp_rd = 0;

  logic [31:0] wd [4];
  rsp_t        rs [4];
  logic [7:0]  lit_rd1 [5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pops_seen = 0, gnts_seen = 0, tx_seen = 0;
  int last_pop_cyc = 0, first_tx_cyc = 0, stall_cyc = 0, stall_at = -1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, required none", name);
  endfunction

  // ---------------- environment driver (inputs change 1 time unit after posedge) -------------
  logic        rx_has = 1'b0, gnt_r = 1'b0, valid_r = 1'b0, err_r = 1'b0, intg_r = 1'b0;
  logic        tx_ready_r = 1'b1;
  logic [31:0] rdata_r = '0;
  int pops_done = 0, gnts_done = 0, req_age = 0, rsp_wait = -1, stall_cnt = 0, stall_fired = -1;

  assign rx_valid_i = rst_ni && rx_has;
  assign rx_data_i  = rx_has ? rx_mem[rx_rd] : 8'h00;
  assign gnt_i      = rst_ni && gnt_r;
  assign valid_i    = rst_ni && valid_r;
  assign rdata_i    = rdata_r;
  assign err_i      = err_r;
  assign intg_err_i = intg_r;
  assign tx_ready_i = tx_ready_r;

  always @(posedge clk_i) begin
    #1;
    if (!rst_ni) begin
      rx_rd = rx_wr;
      pops_done = pops_seen;
      rsp_rd = rsp_wr;
      gnts_done = gnts_seen;
      rsp_wait = -1;
      rx_has = 1'b0;
      gnt_r = 1'b0;
      valid_r = 1'b0;
      req_age = 0;
      stall_cnt = 0;
      tx_ready_r = 1'b1;
    end else begin
      while (pops_done < pops_seen) begin
        rx_rd++;
        pops_done++;
      end
      rx_has = rx_rd < rx_wr;
      gnt_r = req_o && (req_age >= 1);
      req_age = req_o ? req_age + 1 : 0;
      if (gnts_done < gnts_seen) begin
        gnts_done = gnts_seen;
        rsp_wait = 2;
      end
      valid_r = 1'b0;
      if (rsp_wait == 0) begin
        if (rsp_rd < rsp_wr) begin
          {rdata_r, err_r, intg_r} = rsp_mem[rsp_rd];
          rsp_rd++;
        end else begin
          {rdata_r, err_r, intg_r} = '0;
        end
        valid_r = 1'b1;
        rsp_wait = -1;
      end else if (rsp_wait > 0) begin
        rsp_wait--;
      end
      if (stall_at >= 0 && tx_seen == stall_at && stall_fired != stall_at) begin
        stall_cnt = 5;
        stall_fired = stall_at;
      end
      tx_ready_r = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
    end
  end

  // ---------------- compare process (samples on negedge) ----------------
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0, prev_txv = 1'b0;
  logic        prev_txr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [7:0]  prev_txd = '0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      check("rst_ctl", {23'd0, rx_pop_o, tx_valid_o, req_o, we_o, busy_o, be_o}, 32'd0);
      check("rst_txdata", {24'd0, tx_data_o}, 32'd0);
      check("rst_addr", addr_o, 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
      exp_tx_rd = exp_tx_wr;
      exp_op_rd = exp_op_wr;
      prev_req = 1'b0;
      prev_txv = 1'b0;
    end else begin
      if (rx_pop_o) begin
        if (!rx_valid_i) flag("pop_without_valid");
        pops_seen++;
        last_pop_cyc = cyc;
      end
      if (tx_valid_o || req_o) check("pop_while_busy", {31'd0, rx_pop_o}, 32'd0);
      if (req_o) begin
        check("be", {28'd0, be_o}, 32'hF);
        if (prev_req && !prev_gnt) begin
          check("req_addr_stable", addr_o, prev_addr);
          check("req_we_stable", {31'd0, we_o}, {31'd0, prev_we});
          check("req_wdata_stable", wdata_o, prev_wdata);
        end
        if (gnt_i) begin
          if (exp_op_rd < exp_op_wr) begin
            check("op_addr", addr_o, exp_op[exp_op_rd].addr);
            check("op_we", {31'd0, we_o}, {31'd0, exp_op[exp_op_rd].we});
            if (exp_op[exp_op_rd].we) check("op_wdata", wdata_o, exp_op[exp_op_rd].wdata);
            exp_op_rd++;
          end else begin
            flag("unexpected_req");
          end
          gnts_seen++;
        end
      end
      if (tx_valid_o) begin
        if (!prev_txv) first_tx_cyc = cyc;
        if (prev_txv && !prev_txr) check("tx_stable", {24'd0, tx_data_o}, {24'd0, prev_txd});
        if (!tx_ready_i) stall_cyc++;
        if (tx_ready_i) begin
          if (exp_tx_rd < exp_tx_wr) begin
            check("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_tx[exp_tx_rd]});
            exp_tx_rd++;
          end else begin
            flag("unexpected_tx");
          end
          tx_seen++;
        end
      end
      prev_req = req_o;
      prev_gnt = gnt_i;
      prev_addr = addr_o;
      prev_we = we_o;
      prev_wdata = wdata_o;
      prev_txv = tx_valid_o;
      prev_txr = tx_ready_i;
      prev_txd = tx_data_o;
    end
  end

  // ---------------- frame-level model ----------------
  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_tx[exp_tx_wr] = b;
    exp_tx_wr++;
  endtask

  // Builds the command frame and predicts the bus operations and the TX response,
  // using wd[] as write words and rs[] as the bus responses per word.
  task automatic send_cmd(input bit wr, input int len, input logic [31:0] base);
    logic [7:0] sts;
    logic [3:0] lf;
    lf = 4'(len - 1);
    push_rx({wr, 3'b000, lf});
    if (len > 4) begin
      push_tx(STS_BAD_LEN);
      return;
    end
    for (int b = 0; b < 4; b++) push_rx(base[8*b +: 8]);
    sts = STS_OK;
    for (int i = 0; i < len; i++) begin
      if (wr) for (int b = 0; b < 4; b++) push_rx(wd[i][8*b +: 8]);
      exp_op[exp_op_wr] = '{addr: base + 32'(4 * i), we: wr, wdata: wr ? wd[i] : 32'd0};
      exp_op_wr++;
      rsp_mem[rsp_wr] = rs[i];
      rsp_wr++;
      if (rs[i].intg) begin
        sts = STS_INTG_ERR;
        break;
      end
      if (rs[i].err) begin
        sts = STS_BUS_ERR;
        break;
      end
      if (!wr) for (int b = 0; b < 4; b++) push_tx(rs[i].rdata[8*b +: 8]);
    end
    push_tx(sts);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk_i);
    while ((busy_o || rx_rd < rx_wr || exp_tx_rd < exp_tx_wr) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) flag({name, "_bound"});
    repeat (3) @(negedge clk_i);
    check({name, "_tx_left"}, exp_tx_wr - exp_tx_rd, 0);
    check({name, "_op_left"}, exp_op_wr - exp_op_rd, 0);
    check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  function automatic void clear_stim();
    for (int i = 0; i < 4; i++) begin
      wd[i] = '0;
      rs[i] = '0;
    end
  endfunction

  initial begin
    int t, o, s, n;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Read one word at 0x10
    clear_stim();
    rs[0] = '{rdata: 32'hDEADBEEF, err: 1'b0, intg: 1'b0};
    t = exp_tx_wr;
    o = exp_op_wr;
    send_cmd(1'b0, 1, 32'h10);
    check("pin_rd1_count", exp_tx_wr - t, 5);
    for (int i = 0; i < 5; i++) check("pin_rd1_tx", {24'd0, exp_tx[t+i]}, {24'd0, lit_rd1[i]});
    check("pin_rd1_addr", exp_op[o].addr, 32'h10);
    wait_idle("rd1");

    // Write two words at 0x100
    clear_stim();
    wd[0] = 32'h44332211;
    wd[1] = 32'h88776655;
    t = exp_tx_wr;
    o = exp_op_wr;
    send_cmd(1'b1, 2, 32'h100);
    check("pin_wr2_rx_cmd", {24'd0, rx_mem[rx_wr-13]}, 32'h81);
    check("pin_wr2_addr1", exp_op[o+1].addr, 32'h104);
    check("pin_wr2_wdata1", exp_op[o+1].wdata, 32'h88776655);
    check("pin_wr2_tx", {24'd0, exp_tx[t]}, 32'h00);
    wait_idle("wr2");

    // Bus error on the second of three reads
    clear_stim();
    rs[0] = '{rdata: 32'h11223344, err: 1'b0, intg: 1'b0};
    rs[1] = '{rdata: 32'h0, err: 1'b1, intg: 1'b0};
    rs[2] = '{rdata: 32'h55667788, err: 1'b0, intg: 1'b0};
    t = exp_tx_wr;
    send_cmd(1'b0, 3, 32'h20);
    check("pin_berr_count", exp_tx_wr - t, 5);
    check("pin_berr_sts", {24'd0, exp_tx[t+4]}, 32'h01);
    wait_idle("berr");

    // Integrity error has priority over bus error
    clear_stim();
    rs[0] = '{rdata: 32'hFFFF0000, err: 1'b1, intg: 1'b1};
    t = exp_tx_wr;
    send_cmd(1'b0, 1, 32'h44);
    check("pin_intg_sts", {24'd0, exp_tx[t]}, 32'h02);
    wait_idle("intg");

    // Length above MaxBurst
    clear_stim();
    t = exp_tx_wr;
    send_cmd(1'b0, 8, 32'h0);
    check("pin_badlen_cmd", {24'd0, rx_mem[rx_wr-1]}, 32'h07);
    check("pin_badlen_sts", {24'd0, exp_tx[t]}, 32'h03);
    wait_idle("badlen");

    // Timeout after two address bytes
    push_rx(8'h80);
    push_rx(8'h00);
    push_rx(8'h02);
    push_tx(STS_TIMEOUT);
    wait_idle("tmo");
    check("tmo_delay", first_tx_cyc - last_pop_cyc, 9);  // 8 idle cycles, then TX visible

    // TX back-pressure mid-read while the next frame waits in the FIFO
    clear_stim();
    s = stall_cyc;
    stall_at = tx_seen + 2;
    rs[0] = '{rdata: 32'h01020304, err: 1'b0, intg: 1'b0};
    rs[1] = '{rdata: 32'hA5A55A5A, err: 1'b0, intg: 1'b0};
    send_cmd(1'b0, 2, 32'h200);
    clear_stim();
    wd[0] = 32'hCAFEF00D;
    send_cmd(1'b1, 1, 32'h300);
    wait_idle("bp");
    check("bp_stall_cycles", stall_cyc - s, 5);

    // Address wrap
    clear_stim();
    rs[0] = '{rdata: 32'h00000000, err: 1'b0, intg: 1'b0};
    rs[1] = '{rdata: 32'hFFFFFFFF, err: 1'b0, intg: 1'b0};
    o = exp_op_wr;
    send_cmd(1'b0, 2, 32'hFFFFFFFC);
    check("pin_wrap_addr1", exp_op[o+1].addr, 32'h00000000);
    wait_idle("wrap");

    // Reset in the middle of a write frame emits nothing
    t = tx_seen;
    o = gnts_seen;
    push_rx(8'h81);
    push_rx(8'h00);
    push_rx(8'h04);
    push_rx(8'h00);
    push_rx(8'h00);
    push_rx(8'hAA);
    push_rx(8'hBB);
    n = 0;
    while (rx_rd < rx_wr && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) flag("rstmid_bound");
    @(negedge clk_i);
    check("rstmid_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    check("rstmid_idle", {31'd0, busy_o}, 32'd0);
    check("rstmid_no_tx", tx_seen - t, 0);
    check("rstmid_no_req", gnts_seen - o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Parametrised successor to the single-purpose UART-to-host bridge.
- Parses a framed command byte stream from the UART RX FIFO into word read/write bursts on the host-adapter request interface, and returns read data plus a status byte on a TX byte stream.
- Sits between uart_core's streaming ports and the tlul_adapter_host request interface inside the uart wrapper.
- Supports configurable address width, burst length up to MaxBurst, and an inter-byte RX timeout.

Parameters:
- AddrBytes, 4, number of address bytes per command (1..4), little-endian; upper unsent bytes zero.
- MaxBurst, 16, maximum words per command (1..16).
- TimeoutCycles, 1024, idle clocks allowed between command bytes; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rx_valid_i  in  1  RX FIFO has a byte
- rx_data_i  in  8  RX FIFO head byte
- rx_pop_o  out  1  one-cycle pop; byte consumed this cycle
- tx_valid_o  out  1  response byte valid
- tx_data_o  out  8  response byte
- tx_ready_i  in  1  TX sink accepts byte
- req_o  out  1  bus request
- gnt_i  in  1  request accepted
- addr_o  out  32  word address, bits[1:0]=0
- we_o  out  1  write enable
- wdata_o  out  32  write data
- be_o  out  4  byte enables, always 4'hF
- valid_i  in  1  response valid
- rdata_i  in  32  read data
- err_i  in  1  bus error
- intg_err_i  in  1  integrity error
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset mid-operation abandons the command; nothing is emitted.
- Frame format:
  - CMD byte: bit7 = write; bits[3:0] = len-1; bits[6:4] ignored.
  - Then AddrBytes address bytes, LSB first.
  - Write frames then carry len*4 data bytes, each word LSB first.
- rx_pop_o = rx_valid_i && state in {IDLE, ADDR, WDATA}; the byte is captured in the same cycle.
- States and transitions:
  - IDLE: pop CMD. If len > MaxBurst go to TX_STATUS with status 0x03; otherwise go to ADDR.
  - ADDR: collect AddrBytes bytes, then go to WDATA (write) or REQ (read).
  - WDATA: assemble 4 bytes, then go to REQ.
  - REQ: req_o=1 and addr/we/wdata stable until the gnt_i cycle, then go to WAIT_RSP. req_o drops the cycle after gnt.
  - WAIT_RSP: on valid_i:
    - intg_err_i sets status 0x02; else err_i sets status 0x01 (intg has priority). On error go to TX_STATUS; the remaining burst is skipped.
    - Read OK: latch rdata, go to TX_DATA.
    - Write OK: increment index; if index==len go to TX_STATUS with 0x00, else go to WDATA.
  - TX_DATA: emit 4 bytes LSB first. tx_valid_o stays high and tx_data_o stable until tx_ready_i. Then increment index; if index==len go to TX_STATUS with 0x00, else go to REQ.
  - TX_STATUS: emit the status byte, then go to IDLE.
- Address for word i = base + 4*i, mod 2^32 (wraps silently).
- Only one outstanding transaction. valid_i outside WAIT_RSP is ignored.
- Timeout:
  - Counter clears on every pop; it counts only in ADDR/WDATA while rx_valid_i=0.
  - On reaching TimeoutCycles, go to TX_STATUS with status 0x04. Partially received data is discarded and no bus request is issued for the incomplete word.
- Read response = completed words' bytes, then the status byte. Write response = status byte only.
- A byte arriving while in TX/REQ/WAIT stays in the FIFO (no pop).

Decomposition:
- Shared package uart_cmd_bridge_pkg holds:
  - state enum
  - status constants: STS_OK=8'h00, STS_BUS_ERR=8'h01, STS_INTG_ERR=8'h02, STS_BAD_LEN=8'h03, STS_TIMEOUT=8'h04
  - CMD field positions: CmdWrBit=7, CmdLenMsb=3
- Single module; no sub-module needed. The byte shift/assemble logic is shared by the address, wdata and rdata paths.

Test Plan:
- Read 1 word: RX 00, 10,00,00,00; bus returns rdata=0xDEADBEEF -> one req at addr 0x10, we=0; TX EF,BE,AD,DE,00.
- Write 2 words: RX 81, 00,01,00,00, 11,22,33,44, 55,66,77,88 -> writes 0x44332211 @0x100, 0x88776655 @0x104; TX 00 only.
- Bus error: read len 3 at 0x20, err_i on the 2nd response -> TX 4 bytes of word0, then 01; no third req.
- Integrity priority: err_i=1 and intg_err_i=1 together -> status 02.
- Bad length with MaxBurst=4: CMD 0x07 -> no req; TX 03; busy_o returns to 0.
- Timeout with TimeoutCycles=8: CMD 80 plus 2 address bytes, then silence -> TX 04 after 8 idle cycles, no req.
- Back-pressure: hold tx_ready_i=0 for 5 cycles mid-read -> tx_data_o stable and no RX pops.
- Wrap: read len 2 at 0xFFFFFFFC -> second addr_o=0x00000000.
